// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction store and its loader.
// Store depth and word width are used by both the ROM and imem_loader.
package riscv_pkg;

    localparam int IMEM_WIDTH    = 32;
    localparam int IMEM_NUM_INST = 19;
    localparam int IMEM_CNT_W    = 5;

    localparam logic [31:0] NOP_INST = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } ld_state_e;

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word assembler shared by the program and checksum phases.
// word_done/word_nxt describe the word completing this cycle; word_valid/word follow one cycle later.
module byte_to_word_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             byte_vld,
    input  logic [7:0]       byte_data,
    output logic             word_done,
    output logic [WIDTH-1:0] word_nxt,
    output logic             word_valid,
    output logic [WIDTH-1:0] word
);

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic             vld_q, vld_d;

    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        vld_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (byte_vld) begin
            asm_d[{cnt_q, 3'b000} +: 8] = byte_data;
            cnt_d = cnt_q + 2'd1;
            vld_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            asm_q <= '0;
            vld_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            vld_q <= vld_d;
        end
    end

    assign word_done  = byte_vld && !clr && (cnt_q == 2'd3);
    assign word_nxt   = asm_d;
    assign word_valid = vld_q;
    assign word       = asm_q;

endmodule

// File: rtl/imem_loader.sv
// Host-driven instruction store writer: assembles bytes into words, writes them at pc-style
// byte addresses, checks a trailing XOR checksum and holds the core in reset meanwhile.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int WIDTH    = IMEM_WIDTH,
    parameter int NUM_INST = IMEM_NUM_INST,
    parameter int CNT_W    = IMEM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(NUM_INST);

    ld_state_e        state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    logic             xfer;
    logic             pk_clr;
    logic             pk_done;
    logic [WIDTH-1:0] pk_nxt;
    logic             pk_word_valid;
    logic [WIDTH-1:0] pk_word;

    assign busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign cpu_hold = busy;
    assign in_ready = busy;
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);
    assign xfer     = in_valid && in_ready;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    byte_to_word_packer #(.WIDTH(WIDTH)) u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clr        (pk_clr),
        .byte_vld   (xfer),
        .byte_data  (in_data),
        .word_done  (pk_done),
        .word_nxt   (pk_nxt),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pk_clr    = 1'b0;

        // The packer still holds the just-written word during the write cycle.
        if (wr_en_q && pk_word_valid) begin
            csum_d = csum_q ^ pk_word;
        end

        if (abort) begin
            state_d = ST_IDLE;
            pk_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        pk_clr = 1'b1;
                        num_d  = num_words;
                        idx_d  = '0;
                        csum_d = '0;
                        if (num_words > MAX_WORDS) begin
                            state_d = ST_ERR;
                        end else if (num_words == '0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (pk_done) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = pk_nxt;
                        wr_addr_d = {{(WIDTH-CNT_W-2){1'b0}}, idx_q, 2'b00};
                        // Index stops at the last word so it never points past the store.
                        if (idx_q == num_q - 1'b1) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (pk_done) begin
                        state_d = (pk_nxt == csum_q) ? ST_DONE : ST_ERR;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a program-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  num_words = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, wr_en, busy, cpu_hold, done, err;
    logic [31:0] wr_addr, wr_data;

    int checks = 0;
    int failures = 0;

    logic [63:0] wq[$];
    logic [31:0] prog[$];

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (wr_en) wq.push_back({wr_addr, wr_data});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xor_all();
        logic [31:0] x = '0;
        foreach (prog[i]) x ^= prog[i];
        return x;
    endfunction

    task automatic do_start(input logic [4:0] n);
        start = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("byte_accept", {63'd0, acc}, 64'd1);
        repeat (gap) @(negedge clk);
    endtask

    // gap < 0 selects a random 0..3 idle cycles between bytes
    task automatic run_load(input logic [31:0] cs, input int gap, input string tag, input bit mid_start);
        logic [31:0] x;
        int n;
        int g;
        bit good;
        x    = xor_all();
        n    = prog.size();
        good = (cs == x);
        wq.delete();
        do_start(n[4:0]);
        chk({tag, "_hold"}, {63'd0, cpu_hold}, 64'd1);
        foreach (prog[i]) begin
            for (int k = 0; k < 4; k++) begin
                g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
                send_byte(prog[i][8*k +: 8], g);
                if (mid_start && i == 0 && k == 0) do_start(5'd0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            send_byte(cs[8*k +: 8], (k == 3) ? 0 : g);
        end
        chk({tag, "_done"}, {63'd0, done}, {63'd0, good});
        chk({tag, "_err"}, {63'd0, err}, {63'd0, !good});
        chk({tag, "_hold_end"}, {63'd0, cpu_hold}, 64'd0);
        chk({tag, "_nwr"}, 64'(wq.size()), 64'(n));
        foreach (prog[i]) begin
            if (i < wq.size()) chk({tag, "_wr"}, wq[i], {32'(i * 4), prog[i]});
        end
    endtask

    initial begin
        logic [31:0] cs;
        int n;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hold", {63'd0, cpu_hold}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_flags", {62'd0, done, err}, 64'd0);
        chk("rst_wr", {31'd0, wr_en, wr_addr}, 64'd0);
        chk("rst_wdata", {32'd0, wr_data}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // basic load with the reference program
        prog = '{32'h00A08093, 32'h00A10113};
        run_load(32'h00018180, 0, "basic", 1'b0);

        // bad checksum
        run_load(32'h0, 1, "badcs", 1'b0);

        // length overflow
        wq.delete();
        do_start(5'd20);
        chk("ovf_err", {63'd0, err}, 64'd1);
        chk("ovf_done", {63'd0, done}, 64'd0);
        chk("ovf_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            chk("ovf_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ovf_nwr", 64'(wq.size()), 64'd0);
        chk("ovf_err_hold", {63'd0, err}, 64'd1);

        // gaps between bytes
        prog = '{32'h00312233};
        run_load(32'h00312233, 3, "gaps", 1'b0);

        // abort mid-word
        prog = '{32'h11223344, 32'hA5A5A5A5};
        wq.delete();
        do_start(5'd2);
        for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 0);
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_flags", {62'd0, done, err}, 64'd0);
        chk("abort_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_nwr", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) chk("abort_wr0", wq[0], {32'd0, 32'h11223344});
        prog = '{$urandom()};
        run_load(xor_all(), -1, "post_abort", 1'b0);

        // abort and start together from DONE: abort wins
        abort = 1'b1;
        start = 1'b1;
        num_words = 5'd1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abst_busy", {63'd0, busy}, 64'd0);
        chk("abst_flags", {62'd0, done, err}, 64'd0);

        // asynchronous reset mid-load, while a write strobe is up
        prog = '{32'hCAFEF00D, 32'h12345678};
        do_start(5'd2);
        for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 0);
        chk("arst_pre_wr", {63'd0, wr_en}, 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_hold", {63'd0, cpu_hold}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_wr", {63'd0, wr_en}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_idle", {59'd0, busy, cpu_hold, in_ready, done, err}, 64'd0);
        chk("arst_wport", {wr_addr, wr_data}, 64'd0);
        chk("arst_wren", {63'd0, wr_en}, 64'd0);

        // empty program and full-depth program boundaries
        prog.delete();
        run_load(32'h0, -1, "empty", 1'b0);
        prog.delete();
        for (int i = 0; i < 19; i++) prog.push_back($urandom());
        run_load(xor_all(), -1, "full", 1'b0);

        // randomized programs, one with an ignored start while busy
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(19, 1));
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom());
            cs = xor_all();
            if ($urandom_range(1, 0) == 0) cs ^= (32'h1 << $urandom_range(31, 0));
            run_load(cs, -1, "rand", (it == 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction store.
- Accepts a little-endian byte stream from a host link (UART/debug bridge) and assembles it into 32-bit instruction words.
- Writes each word into the instruction ROM's load port at byte addresses matching the core's pc (word index × 4), then verifies a trailing XOR checksum.
- Holds the core in reset (cpu_hold) for the whole load, so fetch never sees a partially written program.

Parameters:
- WIDTH, 32, instruction word width; must be 32 (four bytes per word).
- NUM_INST, 19, instruction store depth in words; the last slot is reserved for the NO-OP terminator, but the loader may write it.
- CNT_W, 5, width of the word counter and num_words; must satisfy 2^CNT_W > NUM_INST.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- num_words  in  CNT_W  number of program words to follow; sampled with start.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- wr_en  out  1  one-cycle write strobe to the instruction store.
- wr_addr  out  WIDTH  byte address of the write; always a multiple of 4.
- wr_data  out  WIDTH  assembled instruction word.
- busy  out  1  high in LOAD and CHECK.
- cpu_hold  out  1  equals busy; the core is held in reset while high.
- done  out  1  level; checksum matched, program valid.
- err  out  1  level; bad length or checksum mismatch.

Behaviour:
Reset (rst low, asynchronous):
- State IDLE; all outputs 0.
- Byte counter, word counter, assembly register and running checksum cleared.

Handshake:
- A byte transfers when in_valid && in_ready.
- in_ready = 1 only in LOAD and CHECK.
- The host may insert gaps (in_valid low) freely; no state advances without a transfer.

States:
- IDLE: on start, capture num_words and clear done and err.
  - num_words > NUM_INST -> ERR the next cycle; no writes are issued.
  - num_words == 0 -> CHECK.
  - Otherwise -> LOAD.
- LOAD: byte k of a word lands in bits [8k+7:8k], k = 0..3 (little-endian).
  - On the 4th byte transfer, the next cycle carries wr_en = 1 for exactly one cycle.
  - wr_data is the assembled word; wr_addr = word_index × 4.
  - The running checksum XORs in the word and word_index increments.
  - When word_index reaches num_words, the state is CHECK in the same cycle as the final wr_en.
- CHECK: accept 4 bytes (little-endian) and compare against the running XOR.
  - Equal -> DONE.
  - Unequal -> ERR.
  - The transition takes effect the cycle after the 4th byte.
- DONE: done = 1, busy = 0; hold until start or abort.
- ERR: err = 1, busy = 0; hold until start or abort.
  - Words already written stay in the store; the host must reload.

Write-port timing:
- wr_addr and wr_data are registered and only meaningful while wr_en = 1.
- Between writes they hold their last values.

Boundary conditions:
- start while busy: ignored.
- abort with start in the same cycle: abort wins; the next state is IDLE.
- abort mid-word: any partial word is discarded and no wr_en is issued; done and err are cleared.
- A byte presented in IDLE, DONE or ERR is not accepted (in_ready = 0).
- word_index never exceeds NUM_INST − 1, so no out-of-range address is ever driven.
- Reset mid-load: the asynchronous clear drops cpu_hold immediately; any pending wr_en is suppressed.

Decomposition:
- Shared package riscv_pkg holds:
  - NUM_INST and the WIDTH default, also used by the instruction store.
  - The loader state enum: IDLE, LOAD, CHECK, DONE, ERR.
  - The NO-OP constant 32'h0.
- One natural sub-module, byte_to_word_packer:
  - 2-bit byte counter plus 32-bit shift/assembly register.
  - Produces word_valid one cycle after the 4th byte.
  - Shared by the LOAD and CHECK phases, with a clear input driven by abort and start.
- The FSM, address counter and checksum live in imem_loader.

Test Plan:
- Basic load: start with num_words = 2; bytes 93 80 A0 00 13 01 A1 00, then checksum 80 81 01 00.
  - Required: wr_en at addr 0x0 with data 0x00A08093, then at addr 0x4 with data 0x00A10113.
  - Required: done = 1, err = 0, cpu_hold falls after the last checksum byte.
- Bad checksum: same program, checksum bytes 00 00 00 00.
  - Required: both writes occur, then err = 1 and done = 0.
- Length overflow: num_words = 20.
  - Required: err = 1 the next cycle, no wr_en, in_ready stays 0.
- Backpressure and gaps: num_words = 1 with 0x00312233 sent with in_valid low for 3 cycles between each byte.
  - Required: a single wr_en with data 0x00312233 at addr 0x0; checksum 33 22 31 00 gives done.
- Abort mid-word: after 2 bytes of word 1, pulse abort.
  - Required: IDLE, no wr_en.
  - Required: a fresh start with num_words = 1 loads correctly from byte 0.
- Async reset mid-load: drop rst between clock edges during LOAD.
  - Required: cpu_hold, busy and wr_en go 0 immediately; after release the state is IDLE with all outputs 0.
